bram_rd_streamer: RTL and testbench

BRAM_RD_STREAMER -- requirements
Module: bram_rd_streamer

---
 rtl/bram_rd_streamer.sv | 160 ++++++++++++++++
 tb/tb_bram_rd_streamer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_rd_streamer.sv
// bram_rd_streamer: reads a burst of consecutive words from a BRAM with a
// one-cycle registered read port and streams them out on a valid/ready
// interface. A small FIFO absorbs back-pressure. A read is only issued when
// the FIFO has room for it plus every read still in flight.
module bram_rd_streamer #(
    parameter int DATA_WIDTH    = 32,
    parameter int OFF_SET_SHIFT = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [19:0]           base_addr,
    input  logic [13:0]           num_words,
    output logic [19:0]           rd_addr,
    input  logic [DATA_WIDTH-1:0] bram_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [19:0]           index_q;        // next word index to read
    logic [13:0]           remaining_q;    // reads still to issue after the current one
    logic [19:0]           rd_addr_q;
    logic                  s1_q;           // address presented to the BRAM
    logic                  s2_q;           // BRAM has sampled the address; data valid now
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic                  m_valid_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic                  start_burst;
    logic                  start_empty;
    logic                  issue_en;
    logic [19:0]           issue_idx;
    logic                  can_issue;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  last_pop;
    logic [CNT_W:0]        occupancy;

    assign start_burst = (state_q == S_IDLE) && start && (num_words != 14'd0);
    assign start_empty = (state_q == S_IDLE) && start && (num_words == 14'd0);
    assign fifo_push   = s2_q;
    assign fifo_pop    = m_valid_q && m_ready;
    assign occupancy   = {1'b0, count_q} + (CNT_W+1)'(s1_q) + (CNT_W+1)'(s2_q);
    assign can_issue   = occupancy < (CNT_W+1)'(FIFO_DEPTH);
    // The burst is finished when the only word left anywhere leaves the FIFO.
    assign last_pop    = (state_q == S_DRAIN) && fifo_pop && (count_q == CNT_W'(1))
                         && !s1_q && !s2_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_burst) state_d = S_ISSUE;
            S_ISSUE: if ((remaining_q == 14'd0) || (can_issue && (remaining_q == 14'd1)))
                         state_d = S_DRAIN;
            S_DRAIN: if (last_pop) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / issue decode; the first read goes out with the accepting edge.
    always_comb begin
        issue_en  = 1'b0;
        issue_idx = index_q;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start_burst) begin
                    issue_en  = 1'b1;
                    issue_idx = base_addr;
                end
            end
            S_ISSUE: issue_en = (remaining_q != 14'd0) && can_issue;
            default: issue_en = 1'b0;
        endcase
    end

    // Read issue, in-flight tracking and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q     <= '0;
            remaining_q <= '0;
            rd_addr_q   <= '0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (start_burst)
                remaining_q <= num_words - 14'd1;
            else if ((state_q == S_ISSUE) && issue_en)
                remaining_q <= remaining_q - 14'd1;
            if (issue_en) begin
                rd_addr_q <= issue_idx << OFF_SET_SHIFT;
                index_q   <= issue_idx + 20'd1;
            end
            s1_q   <= issue_en;
            s2_q   <= s1_q;
            done_q <= last_pop || start_empty;
        end
    end

    // FIFO occupancy after this cycle's push and pop.
    always_comb begin
        count_d = count_q;
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers, count and registered valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            m_valid_q <= (count_d != '0);
            if (fifo_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // FIFO storage: each entry captures BRAM data when it is the write target.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                mem_q[gi] <= '0;
            else if (fifo_push && (wr_ptr_q == PTR_W'(gi)))
                mem_q[gi] <= bram_data;
        end
    end

    assign rd_addr = rd_addr_q;
    assign m_data  = mem_q[rd_ptr_q];
    assign m_valid = m_valid_q;
    assign done    = done_q;

endmodule

// File: tb/tb_bram_rd_streamer.sv
// Directed testbench for bram_rd_streamer with a registered-read BRAM model.
module tb_bram_rd_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [19:0] base_addr = '0;
    logic [13:0] num_words = '0;
    logic [19:0] rd_addr;
    logic [31:0] bram_data = '0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    bram_rd_streamer #(.DATA_WIDTH(32), .OFF_SET_SHIFT(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_words(num_words), .rd_addr(rd_addr), .bram_data(bram_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // BRAM content is a tag plus the byte address it lives at.
    function automatic logic [31:0] word_at(input logic [19:0] a);
        return {12'hD0A, a};
    endfunction

    // Registered read: data appears one edge after the edge that samples rd_addr.
    always @(posedge clk) bram_data <= word_at(rd_addr);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #7;
        checks++; if ({rd_addr, m_valid, busy, done} !== 23'd0) begin errors++; $display("FAIL reset_ctrl: got %h required 0", {rd_addr, m_valid, busy, done}); end
        checks++; if (m_data !== 32'd0) begin errors++; $display("FAIL reset_mdata: got %h required 0", m_data); end
        tick;
        rst = 1'b0;
        tick;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_idle: busy %b done %b required 0 0", busy, done); end
        $display("test_reset done");
    endtask

    task automatic test_single_burst;
        logic [19:0] ea;
        base_addr = 20'h10; num_words = 14'd4; m_ready = 1'b1; start = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick;
            if (t == 1) start = 1'b0;
            ea = (t >= 4) ? 20'h4C : 20'(32'h40 + 4 * (t - 1));
            checks++; if (rd_addr !== ea) begin errors++; $display("FAIL s1_rd_addr t=%0d: got %h required %h", t, rd_addr, ea); end
            checks++; if (m_valid !== (t >= 3 && t <= 6)) begin errors++; $display("FAIL s1_m_valid t=%0d: got %b", t, m_valid); end
            checks++; if (busy !== (t <= 6)) begin errors++; $display("FAIL s1_busy t=%0d: got %b", t, busy); end
            checks++; if (done !== (t == 7)) begin errors++; $display("FAIL s1_done t=%0d: got %b", t, done); end
            if (t >= 3 && t <= 6) begin
                checks++; if (m_data !== word_at(20'(32'h40 + 4 * (t - 3)))) begin errors++; $display("FAIL s1_m_data t=%0d: got %h required %h", t, m_data, word_at(20'(32'h40 + 4 * (t - 3)))); end
            end
        end
        $display("test_single_burst done");
    endtask

    task automatic test_backpressure;
        int got;
        base_addr = 20'h100; num_words = 14'd8; m_ready = 1'b0; start = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick;
            if (t == 1) start = 1'b0;
            if (t >= 4) begin
                checks++; if (rd_addr !== 20'h40C) begin errors++; $display("FAIL s2_issue_limit t=%0d: got %h required 40c", t, rd_addr); end
            end
            if (t >= 3) begin
                checks++; if (m_valid !== 1'b1 || m_data !== word_at(20'h400)) begin errors++; $display("FAIL s2_hold t=%0d: got %b %h required 1 %h", t, m_valid, m_data, word_at(20'h400)); end
            end
        end
        m_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL s2_early_done: got 1 required 0 after %0d words", got); end
            if (m_valid) begin
                checks++; if (m_data !== word_at(20'(32'h400 + 4 * got))) begin errors++; $display("FAIL s2_order word %0d: got %h required %h", got, m_data, word_at(20'(32'h400 + 4 * got))); end
                got++;
            end
            tick;
        end
        checks++; if (got != 8) begin errors++; $display("FAIL s2_count: got %0d words required 8", got); end
        checks++; if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL s2_end: done %b busy %b m_valid %b required 1 0 0", done, busy, m_valid); end
        tick;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL s2_done_width: got %b required 0", done); end
        $display("test_backpressure done");
    endtask

    task automatic test_zero_length;
        base_addr = 20'h777; num_words = 14'd0; start = 1'b1;
        tick;
        start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL s3_pulse: done %b busy %b m_valid %b required 1 0 0", done, busy, m_valid); end
        checks++; if (rd_addr !== 20'h41C) begin errors++; $display("FAIL s3_rd_addr: got %h required 41c", rd_addr); end
        tick;
        checks++; if (done !== 1'b0 || m_valid !== 1'b0 || rd_addr !== 20'h41C) begin errors++; $display("FAIL s3_after: done %b m_valid %b rd_addr %h required 0 0 41c", done, m_valid, rd_addr); end
        $display("test_zero_length done");
    endtask

    task automatic test_wrap;
        logic [19:0] wa [3];
        logic [19:0] ea;
        wa[0] = 20'hFFFF8; wa[1] = 20'hFFFFC; wa[2] = 20'h00000;
        base_addr = 20'hFFFFE; num_words = 14'd3; m_ready = 1'b1; start = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick;
            if (t == 1) start = 1'b0;
            ea = wa[(t > 3) ? 2 : t - 1];
            checks++; if (rd_addr !== ea) begin errors++; $display("FAIL s4_rd_addr t=%0d: got %h required %h", t, rd_addr, ea); end
            if (t >= 3 && t <= 5) begin
                checks++; if (m_valid !== 1'b1 || m_data !== word_at(wa[t - 3])) begin errors++; $display("FAIL s4_m_data t=%0d: got %b %h required 1 %h", t, m_valid, m_data, word_at(wa[t - 3])); end
            end
            checks++; if (done !== (t == 6)) begin errors++; $display("FAIL s4_done t=%0d: got %b", t, done); end
        end
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid_burst;
        base_addr = 20'h200; num_words = 14'd8; m_ready = 1'b1; start = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick;
            if (t == 1) start = 1'b0;
        end
        checks++; if (m_data !== word_at(20'h80C)) begin errors++; $display("FAIL s5_word3: got %h required %h", m_data, word_at(20'h80C)); end
        rst = 1'b1;
        #1;
        checks++; if ({rd_addr, m_valid, busy, done} !== 23'd0 || m_data !== 32'd0) begin errors++; $display("FAIL s5_async_clear: ctrl %h m_data %h required 0 0", {rd_addr, m_valid, busy, done}, m_data); end
        tick;
        rst = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            tick;
            checks++; if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL s5_quiet t=%0d: done %b busy %b m_valid %b required 0 0 0", t, done, busy, m_valid); end
        end
        base_addr = 20'h300; num_words = 14'd2; start = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            tick;
            if (t == 1) start = 1'b0;
            if (t <= 2) begin
                checks++; if (rd_addr !== 20'(32'hC00 + 4 * (t - 1))) begin errors++; $display("FAIL s5_rd_addr t=%0d: got %h required %h", t, rd_addr, 20'(32'hC00 + 4 * (t - 1))); end
            end
            if (t == 3 || t == 4) begin
                checks++; if (m_valid !== 1'b1 || m_data !== word_at(20'(32'hC00 + 4 * (t - 3)))) begin errors++; $display("FAIL s5_m_data t=%0d: got %b %h required 1 %h", t, m_valid, m_data, word_at(20'(32'hC00 + 4 * (t - 3)))); end
            end
            checks++; if (done !== (t == 5) || busy !== (t <= 4)) begin errors++; $display("FAIL s5_ctrl t=%0d: done %b busy %b", t, done, busy); end
        end
        $display("test_reset_mid_burst done");
    endtask

    task automatic test_back_to_back;
        base_addr = 20'h20; num_words = 14'd4; m_ready = 1'b1; start = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick;
            if (t == 1) start = 1'b0;
            if (t == 2) begin start = 1'b1; base_addr = 20'h500; num_words = 14'd2; end
            if (t == 3) start = 1'b0;
            if (t >= 3 && t <= 6) begin
                checks++; if (m_valid !== 1'b1 || m_data !== word_at(20'(32'h80 + 4 * (t - 3)))) begin errors++; $display("FAIL s6_first t=%0d: got %b %h required 1 %h", t, m_valid, m_data, word_at(20'(32'h80 + 4 * (t - 3)))); end
            end
            if (t >= 4) begin
                checks++; if (rd_addr !== 20'h8C) begin errors++; $display("FAIL s6_ignored t=%0d: rd_addr %h required 8c", t, rd_addr); end
            end
        end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL s6_done: done %b busy %b required 1 0", done, busy); end
        base_addr = 20'h600; num_words = 14'd2; start = 1'b1;
        for (int u = 1; u <= 5; u++) begin
            tick;
            if (u == 1) start = 1'b0;
            if (u <= 2) begin
                checks++; if (rd_addr !== 20'(32'h1800 + 4 * (u - 1))) begin errors++; $display("FAIL s6_rd_addr u=%0d: got %h required %h", u, rd_addr, 20'(32'h1800 + 4 * (u - 1))); end
            end
            if (u == 3 || u == 4) begin
                checks++; if (m_valid !== 1'b1 || m_data !== word_at(20'(32'h1800 + 4 * (u - 3)))) begin errors++; $display("FAIL s6_second u=%0d: got %b %h required 1 %h", u, m_valid, m_data, word_at(20'(32'h1800 + 4 * (u - 3)))); end
            end
            checks++; if (done !== (u == 5) || busy !== (u <= 4)) begin errors++; $display("FAIL s6_ctrl u=%0d: done %b busy %b", u, done, busy); end
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset;
        test_single_burst;
        test_backpressure;
        test_zero_length;
        test_wrap;
        test_reset_mid_burst;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
